// File: rtl/led_frame_monitor.sv
// led_frame_monitor
//   Receive-side monitor for an 8-bit LED pattern bus. The bus is synchronised
//   through two flops and debounced. Each newly committed frame is queued in a
//   first-word-fall-through FIFO. The block also flags a stalled source and,
//   optionally, records the per-frame dwell time.
//
// Build option:
//   LED_MON_DWELL_EN - when defined, each FIFO entry also stores the dwell count
//                      and rd_dwell shows the head entry's dwell. When undefined,
//                      entries hold only the frame and rd_dwell is tied to 0.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   ena         1 = sampler, debouncer and counters run; FIFO reads always work
//   led_in      asynchronous 8-bit LED bus
//   rd_en       pops the head entry (ignored while rd_valid=0)
//   clr_ovf     clears the overflow sticky flag
//   rd_valid    FIFO non-empty
//   rd_frame    head frame
//   rd_dwell    head dwell (0 when the option is off)
//   level       FIFO occupancy
//   cur_frame   last committed frame
//   stalled     no commit for at least STALL_CYCLES cycles
//   overflow    sticky: a commit was dropped because the FIFO was full
module led_frame_monitor #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned STALL_CYCLES  = 1024,
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [7:0]               led_in,
  input  logic                     rd_en,
  input  logic                     clr_ovf,
  output logic                     rd_valid,
  output logic [7:0]               rd_frame,
  output logic [CNT_W-1:0]         rd_dwell,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               cur_frame,
  output logic                     stalled,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
`ifdef LED_MON_DWELL_EN
  localparam int unsigned EW = 8 + CNT_W;
`else
  localparam int unsigned EW = 8;
`endif

  logic [7:0]       s1_q, s2_q;
  logic [7:0]       cand_q, cand_d;
  logic [SW-1:0]    stab_q, stab_d;
  logic [7:0]       cur_q, cur_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             stalled_q, stalled_d;
  logic             overflow_q, overflow_d;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_w;
  logic [EW-1:0]    head_w;
  logic [EW-1:0]    entry_w;

  logic stab_hit, commit, full, pop, push, drop;

  // Two-flop synchroniser; frozen together with the rest of the sampler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else if (ena) begin
      s1_q <= led_in;
      s2_q <= s1_q;
    end
  end

  // With a single required sample the commit happens the cycle after cand
  // loads, which is any cycle where s2 still matches cand.
  assign stab_hit = (STABLE_CYCLES == 1) ? 1'b1 : (stab_q == SW'(STABLE_CYCLES - 1));
  assign commit   = ena && (s2_q == cand_q) && stab_hit && (cand_q != cur_q);

  assign level_w  = wr_ptr_q - rd_ptr_q;
  assign full     = (level_w == (AW+1)'(DEPTH));
  assign rd_valid = (level_w != '0);
  assign pop      = rd_en && rd_valid;
  assign push     = commit && (!full || pop);
  assign drop     = commit && full && !pop;

  always_comb begin
    cand_d     = cand_q;
    stab_d     = stab_q;
    cur_d      = cur_q;
    dwell_d    = dwell_q;
    stalled_d  = stalled_q;
    overflow_d = overflow_q;
    if (ena) begin
      if (s2_q != cand_q) begin
        cand_d = s2_q;
        stab_d = SW'(1);
      end else if (stab_q != SW'(STABLE_CYCLES)) begin
        stab_d = stab_q + 1'b1;
      end
      if (dwell_q != '1) dwell_d = dwell_q + 1'b1;
      // stalled rises on the same edge that dwell reaches STALL_CYCLES.
      if (32'(dwell_q) >= STALL_CYCLES - 1) stalled_d = 1'b1;
    end
    if (commit) begin
      cur_d     = cand_q;
      dwell_d   = '0;
      stalled_d = 1'b0;
    end
    if (clr_ovf) overflow_d = 1'b0;
    if (drop)    overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q     <= '0;
      stab_q     <= '0;
      cur_q      <= '0;
      dwell_q    <= '0;
      stalled_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      cand_q     <= cand_d;
      stab_q     <= stab_d;
      cur_q      <= cur_d;
      dwell_q    <= dwell_d;
      stalled_q  <= stalled_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry stores the dwell value from before the commit clears it.
`ifdef LED_MON_DWELL_EN
  assign entry_w = {dwell_q, cand_q};
`else
  assign entry_w = cand_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= entry_w;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign head_w    = mem_q[rd_ptr_q[AW-1:0]];
  assign rd_frame  = rd_valid ? head_w[7:0] : '0;
`ifdef LED_MON_DWELL_EN
  assign rd_dwell  = rd_valid ? head_w[EW-1:8] : '0;
`else
  assign rd_dwell  = '0;
`endif
  assign level     = level_w;
  assign cur_frame = cur_q;
  assign stalled   = stalled_q;
  assign overflow  = overflow_q;

endmodule
